rc_cv_network_mux: RTL

Time-multiplexed, N-channel first-order RC node solver for discrete audio models. It generalises the single-node 555 control-voltage filters:
- per-channel runtime-loadable coefficients;
- two driving inputs plus a bias per channel;
- one shared multiplier stepped by a small state machine on every `audio_clk_en` strobe.

It sits between the game-logic sound latches and the 555/VCO models, producing their control voltages.

---
 rtl/rc_cv_network_mux.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/rc_cv_network_mux.sv
// Time-multiplexed N-channel first-order RC node solver with one shared multiplier.
// Define RC_CV_SATURATE_EN to clamp s' and v instead of two's-complement wrapping.
module rc_cv_network_mux #(
    parameter int CHANNELS = 4,
    parameter int W        = 16,
    parameter int HEAD     = 4
) (
    input  logic                          clk,
    input  logic                          I_RST,
    input  logic                          audio_clk_en,
    input  logic [CHANNELS*W-1:0]         in_a,
    input  logic [CHANNELS*W-1:0]         in_b,
    input  logic                          coef_we,
    input  logic [$clog2(CHANNELS)+3-1:0] coef_addr,
    input  logic [15:0]                   coef_data,
    output logic                          coef_ready,
    output logic [CHANNELS*W-1:0]         v_control,
    output logic                          out_valid,
    output logic                          busy,
    output logic                          overrun
);

    localparam int SW  = W + HEAD;
    localparam int ACW = SW + 18;
    localparam int PW  = SW + 16;
    localparam int CHW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int AW  = $clog2(CHANNELS) + 3;
    localparam logic [CHW-1:0] LAST_CH = CHW'(CHANNELS - 1);

    localparam logic signed [ACW-1:0] S_MAX = {{(ACW-SW+1){1'b0}}, {(SW-1){1'b1}}};
    localparam logic signed [ACW-1:0] S_MIN = ~S_MAX;
    localparam logic signed [PW-1:0]  V_MAX = {{(PW-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [PW-1:0]  V_MIN = ~V_MAX;

    typedef enum logic [1:0] {IDLE, MAC, OUT, DONE} state_t;

    state_t         state, state_nx;
    logic [CHW-1:0] ch, ch_nx;
    logic [1:0]     step, step_nx;

    logic signed [15:0]   coef_a  [CHANNELS];
    logic signed [15:0]   coef_b0 [CHANNELS];
    logic signed [15:0]   coef_b1 [CHANNELS];
    logic signed [15:0]   coef_c  [CHANNELS];
    logic signed [15:0]   coef_g  [CHANNELS];
    logic signed [SW-1:0] s_reg   [CHANNELS];
    logic signed [W-1:0]  snap_a  [CHANNELS];
    logic signed [W-1:0]  snap_b  [CHANNELS];
    logic signed [W-1:0]  stage   [CHANNELS];
    logic [CHANNELS*W-1:0] v_reg;
    logic signed [ACW-1:0] acc;
    logic                  ovr_reg;

    logic signed [15:0]    mul_coef;
    logic signed [SW-1:0]  mul_op;
    logic signed [PW-1:0]  prod;
    logic signed [ACW-1:0] s_shift;
    logic signed [SW-1:0]  s_new;
    logic signed [PW-1:0]  v_shift;
    logic signed [W-1:0]   v_new;
    logic [AW-1:0]         wr_ch;
    logic [2:0]            wr_sel;
    logic                  strobe_ok;

    assign wr_ch     = coef_addr >> 3;
    assign wr_sel    = coef_addr[2:0];
    assign strobe_ok = audio_clk_en && (state == IDLE);
    assign v_control = v_reg;
    assign overrun   = ovr_reg;

    // Operand selection for the shared multiplier: four MAC terms, then g*s' in OUT.
    always_comb begin
        mul_coef = '0;
        mul_op   = '0;
        if (state == MAC) begin
            case (step)
                2'd0: begin mul_coef = coef_a[ch];  mul_op = s_reg[ch];        end
                2'd1: begin mul_coef = coef_b0[ch]; mul_op = SW'(snap_a[ch]);  end
                2'd2: begin mul_coef = coef_b1[ch]; mul_op = SW'(snap_b[ch]);  end
                default: begin mul_coef = coef_c[ch]; mul_op[W-1] = 1'b1;     end
            endcase
        end else if (state == OUT) begin
            mul_coef = coef_g[ch];
            mul_op   = s_new;
        end
    end

    assign prod    = mul_coef * mul_op;
    assign s_shift = acc >>> 14;
    assign v_shift = prod >>> 14;

`ifdef RC_CV_SATURATE_EN
    always_comb begin
        if (s_shift > S_MAX)      s_new = SW'(S_MAX);
        else if (s_shift < S_MIN) s_new = SW'(S_MIN);
        else                      s_new = SW'(s_shift);
        if (v_shift > V_MAX)      v_new = W'(V_MAX);
        else if (v_shift < V_MIN) v_new = W'(V_MIN);
        else                      v_new = W'(v_shift);
    end
`else
    always_comb begin
        s_new = SW'(s_shift);
        v_new = W'(v_shift);
    end
`endif

    // Sweep sequencing: 4 MAC steps plus one OUT step per channel, then a single DONE cycle.
    always_comb begin
        state_nx   = state;
        ch_nx      = ch;
        step_nx    = step;
        busy       = (state != IDLE);
        coef_ready = (state == IDLE);
        out_valid  = (state == DONE);
        case (state)
            IDLE: if (audio_clk_en) begin
                state_nx = MAC;
                ch_nx    = '0;
                step_nx  = '0;
            end
            MAC: if (step == 2'd3) state_nx = OUT;
                 else              step_nx  = step + 2'd1;
            OUT: if (ch == LAST_CH) state_nx = DONE;
                 else begin
                     state_nx = MAC;
                     ch_nx    = ch + 1'b1;
                     step_nx  = '0;
                 end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (I_RST) begin
            state   <= IDLE;
            ch      <= '0;
            step    <= '0;
            acc     <= '0;
            ovr_reg <= 1'b0;
            v_reg   <= '0;
            for (int k = 0; k < CHANNELS; k++) begin
                coef_a[k]  <= 16'sd0;
                coef_b0[k] <= 16'sd16384;
                coef_b1[k] <= 16'sd0;
                coef_c[k]  <= 16'sd0;
                coef_g[k]  <= 16'sd16384;
                s_reg[k]   <= '0;
                snap_a[k]  <= '0;
                snap_b[k]  <= '0;
                stage[k]   <= '0;
            end
        end else begin
            state <= state_nx;
            ch    <= ch_nx;
            step  <= step_nx;
            if (audio_clk_en && state != IDLE)
                ovr_reg <= 1'b1;
            for (int k = 0; k < CHANNELS; k++) begin
                if (strobe_ok) begin
                    snap_a[k] <= in_a[k*W +: W];
                    snap_b[k] <= in_b[k*W +: W];
                end
                if (coef_we && state == IDLE && wr_ch == AW'(k)) begin
                    case (wr_sel)
                        3'd0: coef_a[k]  <= coef_data;
                        3'd1: coef_b0[k] <= coef_data;
                        3'd2: coef_b1[k] <= coef_data;
                        3'd3: coef_c[k]  <= coef_data;
                        3'd4: coef_g[k]  <= coef_data;
                        default: ;
                    endcase
                end
            end
            if (state == MAC)
                acc <= (step == 2'd0) ? ACW'(prod) : acc + ACW'(prod);
            if (state == OUT) begin
                s_reg[ch] <= s_new;
                stage[ch] <= v_new;
            end
            // Load all outputs together so they are visible during the DONE cycle.
            if (state == OUT && ch == LAST_CH) begin
                for (int k = 0; k < CHANNELS; k++)
                    v_reg[k*W +: W] <= (ch == CHW'(k)) ? v_new : stage[k];
            end
        end
    end

endmodule
